boid_fb_scheduler: RTL and testbench

Per-frame sequencer for the boid display framebuffer. Once per video frame it erases each boid's previously drawn pixel, then walks all boid processing units through the shared position select bus and writes each boid's new pixel. It sits between the BPU array, the VGA controller's end-of-frame signal and the single write port of the resettable display RAM. It is the only writer of that RAM.

---
 rtl/boid_pkg.sv | 15 +
 rtl/pixel_addr_calc.sv | 20 ++
 rtl/boid_fb_scheduler.sv | 118 +++++++++++
 tb/tb_boid_fb_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared constants and state encoding for the boid framebuffer path.
package boid_pkg;
  localparam int MAX_BOIDS    = 32;
  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int ADDR_W       = 19;
  localparam int IDX_W        = $clog2(MAX_BOIDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ERASE  = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/pixel_addr_calc.sv
// Combinational (x,y) -> linear framebuffer address with visible-area check.
// Shared with the VGA read path; the multiply by 640 is (y<<9)+(y<<7).
module pixel_addr_calc #(
  parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
  parameter int ADDR_W       = boid_pkg::ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext    = ADDR_W'(x);
  assign y_ext    = ADDR_W'(y);
  assign addr     = x_ext + (y_ext << 9) + (y_ext << 7);
  assign in_range = (x < 10'(VIDEO_WIDTH)) && (y < 9'(VIDEO_HEIGHT));
endmodule

// File: rtl/boid_fb_scheduler.sv
// Per-frame framebuffer sequencer: erase every boid's old pixel, then draw each new one.
// Sole writer of the display RAM; a frame_end edge during an update only sets overrun.
module boid_fb_scheduler #(
  parameter int MAX_BOIDS    = boid_pkg::MAX_BOIDS,
  parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
  parameter int ADDR_W       = boid_pkg::ADDR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_end,
  output logic [$clog2(MAX_BOIDS)-1:0] boid_sel,
  input  logic [9:0]                   boid_x,
  input  logic [8:0]                   boid_y,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic                         fb_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);
  import boid_pkg::*;

  localparam int SEL_W = $clog2(MAX_BOIDS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(MAX_BOIDS - 1);

  state_t            state;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  idx_nxt;
  logic              frame_end_q;
  logic              frame_edge;
  logic [ADDR_W-1:0] prev_addr [MAX_BOIDS];
  logic [MAX_BOIDS-1:0] prev_valid;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_ok;

  assign idx_nxt    = idx + SEL_W'(1);
  assign frame_edge = frame_end & ~frame_end_q;
  assign busy       = (state != S_IDLE);

  pixel_addr_calc #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_W      (ADDR_W)
  ) u_addr (
    .x       (boid_x),
    .y       (boid_y),
    .addr    (draw_addr),
    .in_range(draw_ok)
  );

  // Write outputs are registered, so each state loads the write for the next cycle's slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      frame_end_q <= 1'b0;
      prev_valid  <= '0;
      for (int i = 0; i < MAX_BOIDS; i++) prev_addr[i] <= '0;
      boid_sel    <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_end_q <= frame_end;
      done        <= 1'b0;
      fb_we       <= 1'b0;
      fb_wdata    <= 1'b0;
      if (frame_edge && state != S_IDLE) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_edge) begin
            state   <= S_ERASE;
            idx     <= '0;
            fb_we   <= prev_valid[0];
            fb_addr <= prev_addr[0];
          end
        end
        S_ERASE: begin
          if (idx == LAST) begin
            state    <= S_DRAW;
            idx      <= '0;
            boid_sel <= '0;
          end else begin
            idx     <= idx_nxt;
            fb_we   <= prev_valid[idx_nxt];
            fb_addr <= prev_addr[idx_nxt];
          end
        end
        S_DRAW: begin
          fb_we           <= draw_ok;
          fb_wdata        <= draw_ok;
          prev_valid[idx] <= draw_ok;
          if (draw_ok) begin
            fb_addr        <= draw_addr;
            prev_addr[idx] <= draw_addr;
          end
          if (idx == LAST) begin
            state    <= S_FINISH;
            idx      <= '0;
            boid_sel <= '0;
          end else begin
            idx      <= idx_nxt;
            boid_sel <= idx_nxt;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boid_fb_scheduler.sv
// Directed bench for boid_fb_scheduler: per-cycle capture of one update, checked against hand-computed slots.
module tb_boid_fb_scheduler;
  localparam int NB = 32;
  localparam int NREC = 70;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_end;
  logic [4:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic        fb_wdata;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [9:0] bx [NB];
  logic [8:0] by [NB];

  logic        r_we    [NREC+1];
  logic        r_wdata [NREC+1];
  logic [18:0] r_addr  [NREC+1];
  logic        r_busy  [NREC+1];
  logic        r_done  [NREC+1];
  logic        r_ovr   [NREC+1];
  logic [4:0]  r_sel   [NREC+1];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_fb_scheduler dut (
    .clock    (clock),
    .reset    (reset),
    .frame_end(frame_end),
    .boid_sel (boid_sel),
    .boid_x   (boid_x),
    .boid_y   (boid_y),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Raises frame_end at a negedge; record k is the state of cycle t+k where t is the edge cycle.
  task automatic capture(input int edge2_k, input int rst_k);
    frame_end = 1'b1;
    for (int k = 1; k <= NREC; k++) begin
      @(negedge clock);
      r_we[k] = fb_we;  r_wdata[k] = fb_wdata; r_addr[k] = fb_addr;
      r_busy[k] = busy; r_done[k] = done; r_ovr[k] = overrun; r_sel[k] = boid_sel;
      if (k == 1) frame_end = 1'b0;
      if (edge2_k != 0 && k == edge2_k) frame_end = 1'b1;
      if (edge2_k != 0 && k == edge2_k + 1) frame_end = 1'b0;
      if (rst_k != 0 && k == rst_k) reset = 1'b1;
      if (rst_k != 0 && k == rst_k + 1) reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NB; i++) begin bx[i] = '0; by[i] = '0; end
    reset = 1'b1; frame_end = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({fb_we, fb_wdata, fb_addr, boid_sel} !== 26'd0) begin
      fails++; $display("FAIL reset_write_port: got we=%0b wd=%0b addr=%0d sel=%0d, expected all 0", fb_we, fb_wdata, fb_addr, boid_sel);
    end
    tests++;
    if ({busy, done, overrun} !== 3'b000) begin
      fails++; $display("FAIL reset_status: got busy/done/ovr=%b, expected 000", {busy, done, overrun});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_first_frame();
    int erases, draws, bcnt, dcnt;
    logic sel_ok;
    capture(0, 0);
    erases = 0; draws = 0; bcnt = 0; dcnt = 0; sel_ok = 1'b1;
    for (int k = 1; k <= 32; k++) if (r_we[k]) erases++;
    for (int k = 34; k <= 65; k++) if (r_we[k] && r_wdata[k] && r_addr[k] == 19'd0) draws++;
    for (int k = 1; k <= NREC; k++) begin
      if (r_busy[k]) bcnt++;
      if (r_done[k]) dcnt++;
    end
    for (int i = 0; i < NB; i++) if (r_sel[33+i] !== 5'(i)) sel_ok = 1'b0;
    tests++;
    if (erases != 0) begin fails++; $display("FAIL first_erase_count: got %0d, expected 0", erases); end
    tests++;
    if (draws != 32) begin fails++; $display("FAIL first_draw_count: got %0d, expected 32", draws); end
    tests++;
    if (r_done[66] !== 1'b1 || dcnt != 1) begin
      fails++; $display("FAIL first_done_timing: got done@66=%0b pulses=%0d, expected 1 and 1", r_done[66], dcnt);
    end
    tests++;
    if (bcnt != 65 || r_busy[1] !== 1'b1 || r_busy[66] !== 1'b0) begin
      fails++; $display("FAIL first_busy_window: got %0d cycles b1=%0b b66=%0b, expected 65 1 0", bcnt, r_busy[1], r_busy[66]);
    end
    tests++;
    if (!sel_ok || r_sel[1] !== 5'd0 || r_sel[66] !== 5'd0) begin
      fails++; $display("FAIL first_sel_walk: got sel@34=%0d sel@66=%0d, expected 1 and 0", r_sel[34], r_sel[66]);
    end
  endtask

  task automatic test_move();
    bx[5] = 10'd639; by[5] = 9'd479;
    capture(0, 0);
    tests++;
    if ({r_we[39], r_wdata[39], r_addr[39]} !== {2'b11, 19'd307199}) begin
      fails++; $display("FAIL move_draw_corner: got we=%0b wd=%0b addr=%0d, expected 1 1 307199", r_we[39], r_wdata[39], r_addr[39]);
    end
    bx[5] = 10'd10; by[5] = 9'd2;
    capture(0, 0);
    tests++;
    if ({r_we[6], r_wdata[6], r_addr[6]} !== {2'b10, 19'd307199}) begin
      fails++; $display("FAIL move_erase_corner: got we=%0b wd=%0b addr=%0d, expected 1 0 307199", r_we[6], r_wdata[6], r_addr[6]);
    end
    tests++;
    if ({r_we[39], r_wdata[39], r_addr[39]} !== {2'b11, 19'd1290}) begin
      fails++; $display("FAIL move_draw_new: got we=%0b wd=%0b addr=%0d, expected 1 1 1290", r_we[39], r_wdata[39], r_addr[39]);
    end
  endtask

  task automatic test_out_of_range();
    int draws, erases;
    bx[3] = 10'd640; by[3] = 9'd100;
    bx[7] = 10'd5;   by[7] = 9'd480;
    capture(0, 0);
    draws = 0;
    for (int k = 34; k <= 65; k++) if (r_we[k]) draws++;
    tests++;
    if (r_we[37] !== 1'b0 || r_we[41] !== 1'b0 || draws != 30) begin
      fails++; $display("FAIL oor_no_draw: got we3=%0b we7=%0b draws=%0d, expected 0 0 30", r_we[37], r_we[41], draws);
    end
    tests++;
    if ({r_we[4], r_wdata[4], r_addr[4]} !== {2'b10, 19'd0}) begin
      fails++; $display("FAIL oor_prior_erase: got we=%0b wd=%0b addr=%0d, expected 1 0 0", r_we[4], r_wdata[4], r_addr[4]);
    end
    capture(0, 0);
    erases = 0;
    for (int k = 1; k <= 32; k++) if (r_we[k]) erases++;
    tests++;
    if (r_we[4] !== 1'b0 || r_we[8] !== 1'b0 || erases != 30) begin
      fails++; $display("FAIL oor_no_erase: got we3=%0b we7=%0b erases=%0d, expected 0 0 30", r_we[4], r_we[8], erases);
    end
  endtask

  task automatic test_overrun();
    int bcnt, dcnt, draws;
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_initial: got %0b, expected 0", overrun); end
    capture(20, 0);
    bcnt = 0; dcnt = 0; draws = 0;
    for (int k = 1; k <= NREC; k++) begin
      if (r_busy[k]) bcnt++;
      if (r_done[k]) dcnt++;
    end
    for (int k = 34; k <= 65; k++) if (r_we[k] && r_wdata[k]) draws++;
    tests++;
    if (dcnt != 1 || r_done[66] !== 1'b1 || bcnt != 65 || draws != 30) begin
      fails++; $display("FAIL overrun_update_intact: got done=%0d busy=%0d draws=%0d, expected 1 65 30", dcnt, bcnt, draws);
    end
    tests++;
    if (r_ovr[20] !== 1'b0 || r_ovr[22] !== 1'b1) begin
      fails++; $display("FAIL overrun_set: got ovr@20=%0b ovr@22=%0b, expected 0 1", r_ovr[20], r_ovr[22]);
    end
    repeat (10) @(negedge clock);
    tests++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL overrun_sticky: got ovr=%0b busy=%0b, expected 1 0", overrun, busy);
    end
  endtask

  task automatic test_reset_mid();
    int erases, draws, dcnt;
    bx[3] = '0; by[3] = '0; bx[7] = '0; by[7] = '0;
    capture(0, 40);
    tests++;
    if ({r_we[41], r_wdata[41], r_addr[41], r_sel[41], r_busy[41], r_done[41], r_ovr[41]} !== 29'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got we=%0b addr=%0d sel=%0d busy=%0b ovr=%0b, expected all 0",
                        r_we[41], r_addr[41], r_sel[41], r_busy[41], r_ovr[41]);
    end
    capture(0, 0);
    erases = 0; draws = 0; dcnt = 0;
    for (int k = 1; k <= 32; k++) if (r_we[k]) erases++;
    for (int k = 34; k <= 65; k++) if (r_we[k] && r_wdata[k]) draws++;
    for (int k = 1; k <= NREC; k++) if (r_done[k]) dcnt++;
    tests++;
    if (erases != 0 || draws != 32 || dcnt != 1) begin
      fails++; $display("FAIL post_reset_frame: got erases=%0d draws=%0d done=%0d, expected 0 32 1", erases, draws, dcnt);
    end
  endtask

  task automatic test_hold();
    int bcnt, dcnt;
    bcnt = 0; dcnt = 0;
    frame_end = 1'b1;
    for (int c = 0; c < 3 * NREC; c++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    frame_end = 1'b0;
    tests++;
    if (dcnt != 1 || bcnt != 65 || overrun !== 1'b0) begin
      fails++; $display("FAIL hold_single_update: got done=%0d busy=%0d ovr=%0b, expected 1 65 0", dcnt, bcnt, overrun);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    capture(66, 0);
    tests++;
    if (r_done[66] !== 1'b1 || r_busy[67] !== 1'b1 || r_ovr[70] !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: got done66=%0b busy67=%0b ovr=%0b, expected 1 1 0", r_done[66], r_busy[67], r_ovr[70]);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (done) seen = 1'b1;
    end
    tests++;
    if (!seen || n != 62) begin
      fails++; $display("FAIL b2b_second_done: got seen=%0b after %0d cycles, expected 1 after 62", seen, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_end = 1'b0;
    @(negedge clock);
    test_reset();
    test_first_frame();
    test_move();
    test_out_of_range();
    test_overrun();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
